id_ex_alu_issue: RTL and testbench

- ID/EX pipeline stage that produces the ALU's operands and 4-bit Alu_control: the initiator side of the ALU interface.
- Registers decoded instruction fields from ID.
- Decodes ALUOp/funct into Alu_control codes.
- Resolves EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.
- Sits between the decode stage and the 64-bit ALU in the pipelined core.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/alu_ctrl_decode.sv | 37 +++
 rtl/id_ex_alu_issue.sv | 227 ++++++++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined core.
// Holds the datapath widths, the ALUOp encodings seen between the main
// decoder and the ALU control decoder, the 4-bit ALU control codes, and
// the bundle of per-instruction control bits carried down the pipeline.
package pipe_pkg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    // ALUOp as produced by the main decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    // ALU operation select codes.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // R-type funct3 values understood by the ALU control decoder.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Control bits that travel with an instruction into EX.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU control decoder.
// Maps the main decoder's ALUOp plus funct3 / funct7 bit 5 onto the 4-bit
// ALU operation select. Purely combinational so it can sit after pipeline
// registers (ID/EX stage) or directly in a single-cycle datapath.
//
// Ports:
//   alu_op      in  2  ALUOp (00 add, 01 sub, 10 R-type, 11 reserved)
//   funct3      in  3  instruction funct3
//   funct7_b5   in  1  instruction bit 30 (selects sub for R-type 000)
//   alu_control out 4  ALU operation select; ALU_BAD for anything undefined
module alu_ctrl_decode
    import pipe_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_BAD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADD_SUB: alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_control = ALU_AND;
                    F3_OR:      alu_control = ALU_OR;
                    default:    alu_control = ALU_BAD;
                endcase
            end
            default: alu_control = ALU_BAD;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline stage feeding the 64-bit ALU.
// Registers the decoded instruction from ID, resolves EX/MEM and MEM/WB
// forwarding for both source operands, selects the ALU operands, decodes
// the ALU control code, and detects load-use hazards (inserting a bubble
// while the front end is frozen).
//
// Ports:
//   clk, reset               clock (rising edge), async active-high reset
//   id_*                     decoded instruction fields from ID
//   stall                    downstream hold; all stage registers keep value
//   flush                    branch-taken squash; loads a bubble (beats stall)
//   exmem_*, memwb_*         forwarding sources (write enable, rd, value)
//   load_use_stall           combinational: freeze PC and IF/ID this cycle
//   ex_valid                 EX holds a real instruction
//   ex_a, ex_b               ALU operands
//   ex_alu_control           ALU operation select
//   ex_store_data            forwarded rs2, for stores
//   ex_rd, ex_*              registered destination and control bits
//   ex_illegal               valid instruction with an undefined ALU op
module id_ex_alu_issue
    import pipe_pkg::*;
#(
    parameter int XLEN = pipe_pkg::XLEN,
    parameter int RA_W = pipe_pkg::RA_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_control,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_illegal
);

    // ------------------------------------------------------------------
    // Stage registers. Index 0 is rs1, index 1 is rs2.
    // ------------------------------------------------------------------
    logic            valid_reg,     valid_next;
    ctrl_t           ctrl_reg,      ctrl_next;
    logic [RA_W-1:0] rd_reg,        rd_next;
    logic [RA_W-1:0] rs_reg      [2];
    logic [RA_W-1:0] rs_next     [2];
    logic [XLEN-1:0] rs_data_reg [2];
    logic [XLEN-1:0] rs_data_next[2];
    logic [XLEN-1:0] imm_reg,       imm_next;
    logic [1:0]      alu_op_reg,    alu_op_next;
    logic [2:0]      funct3_reg,    funct3_next;
    logic            funct7_b5_reg, funct7_b5_next;
    logic            alu_src_reg,   alu_src_next;

    ctrl_t           id_ctrl;
    logic [RA_W-1:0] id_rs     [2];
    logic [XLEN-1:0] id_rs_data[2];

    assign id_ctrl = '{
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        branch:     id_branch
    };

    assign id_rs[0]      = id_rs1;
    assign id_rs[1]      = id_rs2;
    assign id_rs_data[0] = id_rs1_data;
    assign id_rs_data[1] = id_rs2_data;

    // A load in EX whose destination is read by the instruction in ID
    // cannot be forwarded in time: hold ID and slip a bubble into EX.
    assign load_use_stall = valid_reg && ctrl_reg.mem_read && (rd_reg != '0) &&
                            id_valid && ((rd_reg == id_rs1) || (rd_reg == id_rs2));

    // ------------------------------------------------------------------
    // Next-state selection: flush > stall > load-use bubble > capture.
    // A bubble also clears rs/operand fields so a dead slot never
    // matches a forwarding source.
    // ------------------------------------------------------------------
    always_comb begin
        valid_next     = valid_reg;
        ctrl_next      = ctrl_reg;
        rd_next        = rd_reg;
        imm_next       = imm_reg;
        alu_op_next    = alu_op_reg;
        funct3_next    = funct3_reg;
        funct7_b5_next = funct7_b5_reg;
        alu_src_next   = alu_src_reg;
        for (int i = 0; i < 2; i++) begin
            rs_next[i]      = rs_reg[i];
            rs_data_next[i] = rs_data_reg[i];
        end

        if (flush || (!stall && load_use_stall)) begin
            valid_next     = 1'b0;
            ctrl_next      = '0;
            rd_next        = '0;
            imm_next       = '0;
            alu_op_next    = ALUOP_ADD;
            funct3_next    = '0;
            funct7_b5_next = 1'b0;
            alu_src_next   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                rs_next[i]      = '0;
                rs_data_next[i] = '0;
            end
        end else if (!stall) begin
            valid_next     = id_valid;
            ctrl_next      = id_ctrl;
            rd_next        = id_rd;
            imm_next       = id_imm;
            alu_op_next    = id_alu_op;
            funct3_next    = id_funct3;
            funct7_b5_next = id_funct7_b5;
            alu_src_next   = id_alu_src;
            for (int i = 0; i < 2; i++) begin
                rs_next[i]      = id_rs[i];
                rs_data_next[i] = id_rs_data[i];
            end
        end
    end

    // Reset parks the decode fields on R-type/AND so that the idle stage
    // presents an all-zero ALU control code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            ctrl_reg       <= '0;
            rd_reg         <= '0;
            imm_reg        <= '0;
            alu_op_reg     <= ALUOP_RTYPE;
            funct3_reg     <= F3_AND;
            funct7_b5_reg  <= 1'b0;
            alu_src_reg    <= 1'b0;
            rs_reg[0]      <= '0;
            rs_reg[1]      <= '0;
            rs_data_reg[0] <= '0;
            rs_data_reg[1] <= '0;
        end else begin
            valid_reg      <= valid_next;
            ctrl_reg       <= ctrl_next;
            rd_reg         <= rd_next;
            imm_reg        <= imm_next;
            alu_op_reg     <= alu_op_next;
            funct3_reg     <= funct3_next;
            funct7_b5_reg  <= funct7_b5_next;
            alu_src_reg    <= alu_src_next;
            rs_reg[0]      <= rs_next[0];
            rs_reg[1]      <= rs_next[1];
            rs_data_reg[0] <= rs_data_next[0];
            rs_data_reg[1] <= rs_data_next[1];
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: the younger EX/MEM result beats MEM/WB; x0 never
    // forwards because it is hard-wired to zero.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fwd_data[2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic exmem_hit;
            logic memwb_hit;
            assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_reg[gi]);
            assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_reg[gi]);
            assign fwd_data[gi] = exmem_hit ? exmem_result :
                                  memwb_hit ? memwb_result :
                                              rs_data_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op      (alu_op_reg),
        .funct3      (funct3_reg),
        .funct7_b5   (funct7_b5_reg),
        .alu_control (ex_alu_control)
    );

    assign ex_a          = fwd_data[0];
    assign ex_b          = alu_src_reg ? imm_reg : fwd_data[1];
    assign ex_store_data = fwd_data[1];

    assign ex_valid      = valid_reg;
    assign ex_rd         = rd_reg;
    assign ex_reg_write  = ctrl_reg.reg_write;
    assign ex_mem_read   = ctrl_reg.mem_read;
    assign ex_mem_write  = ctrl_reg.mem_write;
    assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
    assign ex_branch     = ctrl_reg.branch;
    assign ex_illegal    = valid_reg && (ex_alu_control == ALU_BAD);

endmodule

// File: tb/tb_id_ex_alu_issue.sv
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7_b5, id_alu_src;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        load_use_stall, ex_valid;
    logic [63:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_alu_op       (id_alu_op),
        .id_funct3       (id_funct3),
        .id_funct7_b5    (id_funct7_b5),
        .id_alu_src      (id_alu_src),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_branch       (id_branch),
        .stall           (stall),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .load_use_stall  (load_use_stall),
        .ex_valid        (ex_valid),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_alu_control  (ex_alu_control),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_branch       (ex_branch),
        .ex_illegal      (ex_illegal)
    );

    // Vector table record: instruction fields plus the expected ALU code.
    typedef struct {
        string       name;
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic        b5;
        logic        alu_src;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm;
        logic [3:0]  exp_ctrl;
        logic        exp_ill;
    } vec_t;

    // Scoreboard entry: what EX must show one edge after the drive.
    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        ill;
        logic [63:0] a, b, sd;
    } exp_t;

    vec_t vecs[9];
    exp_t exp_q[$];

    function automatic vec_t mkv(string name, logic [1:0] op, logic [2:0] f3, logic b5,
                                 logic src, logic [4:0] rd, logic [63:0] d1, logic [63:0] d2,
                                 logic [63:0] imm, logic [3:0] ctrl, logic ill);
        vec_t v;
        v.name = name; v.alu_op = op; v.funct3 = f3; v.b5 = b5; v.alu_src = src;
        v.rs1 = 5'd2; v.rs2 = 5'd3; v.rd = rd;
        v.d1 = d1; v.d2 = d2; v.imm = imm; v.exp_ctrl = ctrl; v.exp_ill = ill;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(logic v, logic [1:0] op, logic [2:0] f3, logic b5, logic src,
                            logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                            logic [63:0] d1, logic [63:0] d2, logic [63:0] imm,
                            logic rw, logic mr, logic mw, logic mtr, logic br);
        id_valid = v; id_alu_op = op; id_funct3 = f3; id_funct7_b5 = b5; id_alu_src = src;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mtr; id_branch = br;
    endtask

    task automatic fwd_idle();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        exp_t e;

        reset = 1; stall = 0; flush = 0;
        fwd_idle();
        drive_id(0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0] = mkv("r_add",   2'b10, 3'b000, 0, 0, 5'd4,  64'h10, 64'h20, 64'h0,  4'b0010, 0);
        vecs[1] = mkv("r_sub",   2'b10, 3'b000, 1, 0, 5'd5,  64'h30, 64'h40, 64'h0,  4'b0110, 0);
        vecs[2] = mkv("r_and",   2'b10, 3'b111, 0, 0, 5'd6,  64'h50, 64'h60, 64'h0,  4'b0000, 0);
        vecs[3] = mkv("r_or",    2'b10, 3'b110, 0, 0, 5'd7,  64'h70, 64'h80, 64'h0,  4'b0001, 0);
        vecs[4] = mkv("r_bad",   2'b10, 3'b010, 0, 0, 5'd8,  64'h90, 64'hA0, 64'h0,  4'b1111, 1);
        vecs[5] = mkv("op_add",  2'b00, 3'b000, 0, 1, 5'd9,  64'hB0, 64'hC0, 64'h10, 4'b0010, 0);
        vecs[6] = mkv("op_sub",  2'b01, 3'b000, 0, 0, 5'd10, 64'hD0, 64'hE0, 64'h0,  4'b0110, 0);
        vecs[7] = mkv("op_rsvd", 2'b11, 3'b000, 0, 0, 5'd11, 64'hF0, 64'h11, 64'h0,  4'b1111, 1);
        vecs[8] = mkv("r_and_b5",2'b10, 3'b111, 1, 0, 5'd12, 64'h22, 64'h33, 64'h0,  4'b0000, 0);

        // Reset state
        repeat (2) tick();
        check("reset_valid",      ex_valid, 0);
        check("reset_alu_ctrl",   ex_alu_control, 4'b0000);
        check("reset_reg_write",  ex_reg_write, 0);
        check("reset_illegal",    ex_illegal, 0);
        check("reset_rd",         ex_rd, 0);
        check("reset_a",          ex_a, 0);
        check("reset_b",          ex_b, 0);
        check("reset_store",      ex_store_data, 0);
        check("reset_lus",        load_use_stall, 0);
        reset = 0;
        tick();

        // Table-driven decode / operand select through the scoreboard
        for (int i = 0; i < 9; i++) begin
            drive_id(1, vecs[i].alu_op, vecs[i].funct3, vecs[i].b5, vecs[i].alu_src,
                     vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2, vecs[i].imm,
                     1, 0, 0, 0, 0);
            e.name = vecs[i].name; e.valid = 1; e.rd = vecs[i].rd;
            e.ctrl = vecs[i].exp_ctrl; e.ill = vecs[i].exp_ill;
            e.a = vecs[i].d1;
            e.b = vecs[i].alu_src ? vecs[i].imm : vecs[i].d2;
            e.sd = vecs[i].d2;
            exp_q.push_back(e);
            tick();
            if (exp_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_valid"}, ex_valid, e.valid);
                check({e.name, "_ctrl"},  ex_alu_control, e.ctrl);
                check({e.name, "_ill"},   ex_illegal, e.ill);
                check({e.name, "_a"},     ex_a, e.a);
                check({e.name, "_b"},     ex_b, e.b);
                check({e.name, "_sd"},    ex_store_data, e.sd);
                check({e.name, "_rd"},    ex_rd, e.rd);
                $display("[TB] vec %s: ctrl=%b ill=%b a=%0h b=%0h", e.name, ex_alu_control,
                         ex_illegal, ex_a, ex_b);
            end
        end

        // Forwarding priority on rs1
        drive_id(1, 2'b10, 3'b000, 0, 0, 5'd5, 5'd0, 5'd10, 64'h1111, 64'h0, 64'h0, 1, 0, 0, 0, 0);
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 64'hAAAA;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 64'hBBBB;
        #1 check("fwd_exmem", ex_a, 64'hAAAA);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", ex_a, 64'hBBBB);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_x0_regfile", ex_a, 64'h1111);
        $display("[TB] forwarding priority sequence done");
        fwd_idle();
        tick();

        // Immediate select with forwarded rs2
        drive_id(1, 2'b00, 3'b000, 0, 1, 5'd0, 5'd6, 5'd11, 64'h0, 64'h0,
                 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 0, 0);
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 6; exmem_result = 64'h1234;
        #1 check("imm_b", ex_b, 64'hFFFF_FFFF_FFFF_FFF0);
        check("imm_store_fwd", ex_store_data, 64'h1234);
        $display("[TB] immediate select: b=%0h store=%0h", ex_b, ex_store_data);
        fwd_idle();
        tick();

        // Load-use: ld x7 then add x8,x7,x1
        drive_id(1, 2'b00, 3'b000, 0, 1, 5'd1, 5'd0, 5'd7, 64'h0, 64'h0, 64'h8, 1, 1, 0, 1, 0);
        tick();
        drive_id(1, 2'b10, 3'b000, 0, 0, 5'd7, 5'd1, 5'd8, 64'h5, 64'h6, 64'h0, 1, 0, 0, 0, 0);
        #1 check("lu_stall_asserted", load_use_stall, 1);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_rd", ex_rd, 0);
        check("lu_bubble_rw", ex_reg_write, 0);
        check("lu_stall_cleared", load_use_stall, 0);
        tick();
        check("lu_capture_valid", ex_valid, 1);
        check("lu_capture_rd", ex_rd, 8);
        check("lu_capture_ctrl", ex_alu_control, 4'b0010);
        $display("[TB] load-use sequence done");

        // Load to x0 never stalls
        drive_id(1, 2'b00, 3'b000, 0, 1, 5'd1, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1, 1, 0, 1, 0);
        tick();
        drive_id(1, 2'b10, 3'b000, 0, 0, 5'd0, 5'd0, 5'd3, 64'h0, 64'h0, 64'h0, 1, 0, 0, 0, 0);
        #1 check("lu_x0_no_stall", load_use_stall, 0);
        tick();

        // Flush and stall together
        drive_id(1, 2'b01, 3'b000, 0, 0, 5'd1, 5'd2, 5'd9, 64'h0, 64'h0, 64'h0, 1, 1, 1, 1, 1);
        tick();
        check("pre_flush_valid", ex_valid, 1);
        stall = 1; flush = 1;
        tick();
        check("flush_valid", ex_valid, 0);
        check("flush_rw",  ex_reg_write, 0);
        check("flush_mr",  ex_mem_read, 0);
        check("flush_mw",  ex_mem_write, 0);
        check("flush_mtr", ex_mem_to_reg, 0);
        check("flush_br",  ex_branch, 0);
        check("flush_rd",  ex_rd, 0);
        $display("[TB] flush+stall: valid=%b rd=%0d", ex_valid, ex_rd);

        // Stall alone holds for three cycles
        stall = 0; flush = 0;
        drive_id(1, 2'b10, 3'b000, 0, 0, 5'd1, 5'd2, 5'd9, 64'h0, 64'h0, 64'h0, 1, 0, 0, 0, 0);
        tick();
        stall = 1;
        drive_id(1, 2'b11, 3'b010, 0, 0, 5'd3, 5'd4, 5'd12, 64'h0, 64'h0, 64'h0, 0, 1, 1, 1, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_hold_valid", ex_valid, 1);
            check("stall_hold_rd", ex_rd, 9);
            check("stall_hold_rw", ex_reg_write, 1);
            check("stall_hold_ctrl", ex_alu_control, 4'b0010);
            $display("[TB] stall cycle %0d: rd=%0d", c, ex_rd);
        end

        // Reset mid-stall clears without a clock edge
        #2 reset = 1;
        #1;
        check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_ctrl", ex_alu_control, 4'b0000);
        check("rst_mid_rw", ex_reg_write, 0);
        #1 reset = 0;
        stall = 0;
        $display("[TB] reset mid-stall done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
